uart_tx_arbiter: RTL and testbench

Shares one UART transmit line between N_REQ byte requesters on a common clock. Each requester offers a byte via valid/ready, and a round-robin arbiter selects one. An internal serializer emits the byte as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit) at BAUDRATE. Sits between on-chip byte producers and the board-level tx pin; the far end is the UART agent/receiver at the same baud rate.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_serializer.sv | 93 +++++++++
 rtl/uart_tx_arbiter.sv | 86 ++++++++
 tb/tb_uart_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   function automatic int clks_per_bit(input longint clk_hz, input longint baud);
      return int'(clk_hz / baud);
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: one start bit, DATA_BITS data bits LSB first, one stop bit.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CPB = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = (CPB > 2) ? $clog2(CPB) : 1;
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_TICK = CW'(CPB - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   uart_tx_state_t       state;
   logic [CW-1:0]        baud_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 bit_end;

   assign bit_end = (baud_cnt == LAST_TICK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (start) begin
                  shift <= data;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
                  state <= START;
               end else begin
                  tx <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     // tx is registered, so it takes the bit that becomes shift[0] next
                     shift   <= {1'b0, shift[DATA_BITS-1:1]};
                     tx      <= shift[1];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbitration of N_REQ byte requesters onto one shared UART tx line.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUDRATE    = 9600
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [8*N_REQ-1:0]       req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     frame_done
);

   localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUDRATE);
   localparam int IDW = $clog2(N_REQ);

   if (CPB < 2) begin : g_cpb_check
      $error("uart_tx_arbiter: CLK_FREQ_HZ/BAUDRATE must be at least 2");
   end

   logic [IDW-1:0]       rr_ptr;
   logic [IDW-1:0]       win;
   logic                 found;
   logic                 start;
   logic [DATA_BITS-1:0] win_data;
   logic                 ser_busy;
   logic                 ser_done;
   int                   idx;

   // First valid requester at or after rr_ptr, wrapping modulo N_REQ
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   assign start = found & ~ser_busy;

   always_comb begin
      req_ready = '0;
      if (start) req_ready[win] = 1'b1;
   end

   always_comb begin
      win_data = req_data[8*int'(win) +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         grant_id <= '0;
      end else if (start) begin
         grant_id <= win;
         rr_ptr   <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
   end

   uart_tx_serializer #(
      .CPB (CPB)
   ) u_ser (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .data  (win_data),
      .tx    (tx),
      .busy  (ser_busy),
      .done  (ser_done)
   );

   assign busy       = ser_busy;
   assign frame_done = ser_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: CPB=10 instance plus a 50 MHz loopback instance.
module tb_uart_tx_arbiter;

   localparam int CPB    = 10;
   localparam int CPB_LB = 5208;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx;
   logic        busy;
   logic [1:0]  grant_id;
   logic        frame_done;

   logic [3:0]  lb_valid;
   logic [31:0] lb_data;
   logic [3:0]  lb_ready;
   logic        lb_tx;
   logic        lb_busy;
   logic [1:0]  lb_grant_id;
   logic        lb_frame_done;

   int checks = 0;
   int errors = 0;
   int rdy_cnt [4];

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ       (4),
      .CLK_FREQ_HZ (96_000),
      .BAUDRATE    (9600)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx         (tx),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   uart_tx_arbiter #(
      .N_REQ       (4),
      .CLK_FREQ_HZ (50_000_000),
      .BAUDRATE    (9600)
   ) dut_lb (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (lb_valid),
      .req_data   (lb_data),
      .req_ready  (lb_ready),
      .tx         (lb_tx),
      .busy       (lb_busy),
      .grant_id   (lb_grant_id),
      .frame_done (lb_frame_done)
   );

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) rdy_cnt[i] <= rdy_cnt[i] + int'(req_ready[i]);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called in the first START cycle; returns in the last STOP cycle.
   task automatic expect_frame(input string tag, input logic [7:0] b);
      logic [9:0] exp_bits;
      logic [9:0] obs_bits;
      logic       stable;
      exp_bits = {1'b1, b, 1'b0};
      obs_bits = '0;
      stable   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < CPB; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (c == 0) obs_bits[i] = tx;
            else if (tx !== obs_bits[i]) stable = 1'b0;
         end
      end
      check($sformatf("%s frame", tag), 32'(obs_bits), 32'(exp_bits));
      check($sformatf("%s bit_stable", tag), 32'(stable), 32'd1);
   endtask

   task automatic end_of_frame(input string tag);
      @(negedge clk); #1;
      check($sformatf("%s frame_done", tag), 32'(frame_done), 32'd1);
      check($sformatf("%s busy_idle", tag), 32'(busy), 32'd0);
      check($sformatf("%s tx_idle", tag), 32'(tx), 32'd1);
   endtask

   initial begin
      logic [7:0] rx_byte;
      logic       seen_ready;
      logic       seen_busy;
      int         base [4];
      int         wait_cnt;
      int         exp_id;

      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      lb_valid  = '0;
      lb_data   = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst tx", 32'(tx), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst grant", 32'(grant_id), 32'd0);
      check("rst done", 32'(frame_done), 32'd0);
      check("rst lb_tx", 32'(lb_tx), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: single request from requester 2
      @(negedge clk);
      req_valid       = 4'b0100;
      req_data[23:16] = 8'h23;
      #1;
      check("t1 ready", 32'(req_ready), 32'b0100);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("t1 ready_pulse", 32'(req_ready), 32'd0);
      check("t1 grant", 32'(grant_id), 32'd2);
      check("t1 busy", 32'(busy), 32'd1);
      expect_frame("t1", 8'h23);
      end_of_frame("t1");
      @(negedge clk); #1;
      check("t1 done_one_cycle", 32'(frame_done), 32'd0);

      // Test 2: all four requesters after reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      base      = rdy_cnt;
      req_data  = 32'h13121110;
      req_valid = 4'b1111;
      #1;
      for (int j = 0; j < 4; j++) begin
         check($sformatf("t2 ready%0d", j), 32'(req_ready), 32'(1 << j));
         @(negedge clk);
         req_valid[j] = 1'b0;
         #1;
         check($sformatf("t2 grant%0d", j), 32'(grant_id), 32'(j));
         check($sformatf("t2 tx_fall%0d", j), 32'(tx), 32'd0);
         expect_frame($sformatf("t2 byte%0d", j), 8'h10 + 8'(j));
         end_of_frame($sformatf("t2 end%0d", j));
      end
      for (int i = 0; i < 4; i++)
         check($sformatf("t2 ready_count%0d", i), 32'(rdy_cnt[i] - base[i]), 32'd1);

      // Test 3: requesters 0 and 3 held valid continuously
      base      = rdy_cnt;
      req_data  = 32'hA30000A0;
      req_valid = 4'b1001;
      #1;
      for (int f = 0; f < 8; f++) begin
         exp_id = (f % 2 == 0) ? 0 : 3;
         check($sformatf("t3 ready%0d", f), 32'(req_ready), 32'(1 << exp_id));
         @(negedge clk); #1;
         check($sformatf("t3 grant%0d", f), 32'(grant_id), 32'(exp_id));
         expect_frame($sformatf("t3 byte%0d", f), (exp_id == 0) ? 8'hA0 : 8'hA3);
         end_of_frame($sformatf("t3 end%0d", f));
      end
      req_valid = '0;
      check("t3 count0", 32'(rdy_cnt[0] - base[0]), 32'd4);
      check("t3 count3", 32'(rdy_cnt[3] - base[3]), 32'd4);

      // Test 4: requester 1 raises valid while busy and withdraws it
      req_data[7:0] = 8'h77;
      req_valid     = 4'b0001;
      #1;
      check("t4 ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      base            = rdy_cnt;
      req_valid       = 4'b0010;
      req_data[15:8]  = 8'h99;
      #1;
      check("t4 grant", 32'(grant_id), 32'd0);
      seen_ready = 1'b0;
      repeat (50) begin
         @(negedge clk); #1;
         seen_ready |= |req_ready;
      end
      req_valid = '0;
      repeat (49) @(negedge clk);
      end_of_frame("t4");
      seen_busy = 1'b0;
      repeat (30) begin
         @(negedge clk); #1;
         seen_busy |= busy;
      end
      check("t4 no_ready_while_busy", 32'(seen_ready), 32'd0);
      check("t4 no_extra_frame", 32'(seen_busy), 32'd0);
      check("t4 ready1_count", 32'(rdy_cnt[1] - base[1]), 32'd0);

      // Test 5: reset during data bit 4, then rr_ptr restarts at 0
      req_data  = '0;
      req_valid = 4'b0010;
      #1;
      check("t5 ready_pre", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("t5 grant_pre", 32'(grant_id), 32'd1);
      repeat (54) @(negedge clk);
      #1;
      check("t5 tx_bit4", 32'(tx), 32'd0);
      check("t5 busy_bit4", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("t5 async_tx", 32'(tx), 32'd1);
      check("t5 async_busy", 32'(busy), 32'd0);
      check("t5 async_grant", 32'(grant_id), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst       = 1'b0;
      req_data  = 32'hC3005A00;
      req_valid = 4'b1010;
      #1;
      check("t5 ready_post", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("t5 grant_post", 32'(grant_id), 32'd1);
      expect_frame("t5", 8'h5A);
      end_of_frame("t5");

      // Test 6: loopback receiver on the 50 MHz instance
      @(negedge clk);
      lb_data[7:0] = 8'h51;
      lb_valid     = 4'b0001;
      #1;
      check("t6 ready", 32'(lb_ready), 32'b0001);
      @(negedge clk);
      lb_valid = '0;
      wait_cnt = 0;
      while (lb_tx !== 1'b0 && wait_cnt < 100) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("t6 start_timeout", 32'(wait_cnt < 100), 32'd1);
      repeat (CPB_LB / 2) @(negedge clk);
      check("t6 start_bit", 32'(lb_tx), 32'd0);
      rx_byte = '0;
      for (int b = 0; b < 8; b++) begin
         repeat (CPB_LB) @(negedge clk);
         rx_byte[b] = lb_tx;
      end
      repeat (CPB_LB) @(negedge clk);
      check("t6 stop_bit", 32'(lb_tx), 32'd1);
      check("t6 rx_byte", 32'(rx_byte), 32'h51);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
